// File: rtl/sprite_mover.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sprite_mover: per-frame maze sprite position generator                 |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module sprite_mover #(
  parameter int TILE    = 16,
  parameter int STEP    = 1,
  parameter int X_MAX   = 624,
  parameter int Y_MAX   = 464,
  parameter int START_X = 304,
  parameter int START_Y = 368
) (
  input  logic       VGA_CLK,
  input  logic       HRESET,
  input  logic       frame_tick,
  input  logic       dir_req_valid,
  input  logic [1:0] dir_req,
  output logic       wall_qry_valid,
  output logic [5:0] wall_qry_tx,
  output logic [4:0] wall_qry_ty,
  input  logic       wall_rsp_valid,
  input  logic       wall_blocked,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       overrun
);

  localparam int         TILE_SHIFT = $clog2(TILE);
  localparam int         NCOL       = X_MAX / TILE + 1;
  localparam logic [9:0] TILE_MASK  = 10'(TILE - 1);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
  localparam logic [5:0] LAST_COL   = 6'(NCOL - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHK      = 3'd1,
    S_QRY_PEND = 3'd2,
    S_QRY_CUR  = 3'd3,
    S_MOVE     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic       moving_q, moving_d;
  logic       overrun_q, overrun_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic       qv_q, qv_d;
  logic [5:0] tx_q, tx_d;
  logic [4:0] ty_q, ty_d;

  logic       aligned;
  logic       pend_clr;

  // Neighbour tile {col,row}; columns wrap through the tunnel, rows do not.
  function automatic logic [10:0] nbr(input logic [1:0] d, input logic [9:0] x,
                                      input logic [9:0] y);
    logic [5:0] col;
    logic [4:0] row;
    col = 6'(x >> TILE_SHIFT);
    row = 5'(y >> TILE_SHIFT);
    case (d)
      DIR_UP:    row = row - 5'd1;
      DIR_DOWN:  row = row + 5'd1;
      DIR_LEFT:  col = (col == 6'd0) ? LAST_COL : col - 6'd1;
      default:   col = (col == LAST_COL) ? 6'd0 : col + 6'd1;
    endcase
    return {col, row};
  endfunction

  assign aligned = ((x_q | y_q) & TILE_MASK) == 10'd0;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    moving_d     = moving_q;
    overrun_d    = overrun_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    qv_d         = qv_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    pend_clr     = 1'b0;

    if (frame_tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: if (frame_tick) state_d = S_CHK;
      S_CHK: begin
        if (pend_valid_q && (pend_dir_q == (dir_q ^ 2'd1))) begin
          dir_d    = pend_dir_q;
          pend_clr = 1'b1;
          state_d  = S_MOVE;
        end else if (!aligned) begin
          state_d = S_MOVE;
        end else if (pend_valid_q) begin
          {tx_d, ty_d} = nbr(pend_dir_q, x_q, y_q);
          qv_d         = 1'b1;
          state_d      = S_QRY_PEND;
        end else begin
          {tx_d, ty_d} = nbr(dir_q, x_q, y_q);
          qv_d         = 1'b1;
          state_d      = S_QRY_CUR;
        end
      end
      S_QRY_PEND: if (wall_rsp_valid) begin
        // The follow-up query uses the heading that will be in force after this answer.
        if (!wall_blocked) begin
          dir_d        = pend_dir_q;
          pend_clr     = 1'b1;
          {tx_d, ty_d} = nbr(pend_dir_q, x_q, y_q);
        end else begin
          {tx_d, ty_d} = nbr(dir_q, x_q, y_q);
        end
        state_d = S_QRY_CUR;
      end
      S_QRY_CUR: if (wall_rsp_valid) begin
        qv_d = 1'b0;
        if (wall_blocked) begin
          moving_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        moving_d = 1'b1;
        case (dir_q)
          DIR_UP:
            if ({1'b0, y_q} < STEP_W) begin
              y_d      = 10'd0;
              moving_d = 1'b0;
            end else y_d = y_q - STEP_W[9:0];
          DIR_DOWN:
            if ({1'b0, y_q} + STEP_W > Y_MAX_W) begin
              y_d      = Y_MAX_W[9:0];
              moving_d = 1'b0;
            end else y_d = y_q + STEP_W[9:0];
          DIR_LEFT:
            x_d = ({1'b0, x_q} < STEP_W) ? X_MAX_W[9:0] : x_q - STEP_W[9:0];
          default:
            x_d = ({1'b0, x_q} + STEP_W > X_MAX_W) ? 10'd0 : x_q + STEP_W[9:0];
        endcase
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pend_clr) pend_valid_d = 1'b0;
    if (dir_req_valid) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = dir_req;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (HRESET) begin
      state_q      <= S_IDLE;
      x_q          <= 10'(START_X);
      y_q          <= 10'(START_Y);
      dir_q        <= DIR_LEFT;
      moving_q     <= 1'b0;
      overrun_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= 2'd0;
      qv_q         <= 1'b0;
      tx_q         <= 6'd0;
      ty_q         <= 5'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      moving_q     <= moving_d;
      overrun_q    <= overrun_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      qv_q         <= qv_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
    end
  end

  assign wall_qry_valid = qv_q;
  assign wall_qry_tx    = tx_q;
  assign wall_qry_ty    = ty_q;
  assign sprite_x       = x_q;
  assign sprite_y       = y_q;
  assign cur_dir        = dir_q;
  assign moving         = moving_q;
  assign overrun        = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_mover.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sprite_mover: directed vector bench for sprite_mover                |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_sprite_mover;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       dir_req_valid;
  logic [1:0] dir_req;
  logic       wall_qry_valid;
  logic [5:0] wall_qry_tx;
  logic [4:0] wall_qry_ty;
  logic       wall_rsp_valid;
  logic       wall_blocked;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [1:0] cur_dir;
  logic       moving;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_mover dut (
    .VGA_CLK        (clk),
    .HRESET         (rst),
    .frame_tick     (frame_tick),
    .dir_req_valid  (dir_req_valid),
    .dir_req        (dir_req),
    .wall_qry_valid (wall_qry_valid),
    .wall_qry_tx    (wall_qry_tx),
    .wall_qry_ty    (wall_qry_ty),
    .wall_rsp_valid (wall_rsp_valid),
    .wall_blocked   (wall_blocked),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
    .cur_dir        (cur_dir),
    .moving         (moving),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic       req_v;
    logic [1:0] req_d;
    logic       blk0;
    logic       blk1;
    logic [9:0] exp_x;
    logic [9:0] exp_y;
    logic [1:0] exp_dir;
    logic       exp_mov;
    int         exp_nq;
    logic [5:0] exp_tx;
    logic [4:0] exp_ty;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One frame: optional request, a tick, then answer every query seen.
  task automatic run_frame(input logic req_v, input logic [1:0] req_d, input logic b0,
                           input logic b1, output int nq, output logic [5:0] tx,
                           output logic [4:0] ty);
    nq = 0;
    tx = '0;
    ty = '0;
    @(negedge clk);
    dir_req_valid = req_v;
    dir_req       = req_d;
    @(negedge clk);
    dir_req_valid = 1'b0;
    frame_tick    = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wall_rsp_valid = 1'b0;
      if (wall_qry_valid) begin
        nq++;
        if (nq == 1) begin
          tx = wall_qry_tx;
          ty = wall_qry_ty;
        end
        wall_rsp_valid = 1'b1;
        wall_blocked   = (nq == 1) ? b0 : b1;
      end
    end
    wall_rsp_valid = 1'b0;
    wall_blocked   = 1'b0;
  endtask

  initial begin
    int         nq;
    logic [5:0] tx;
    logic [4:0] ty;
    int         k;

    rst            = 1'b1;
    frame_tick     = 1'b0;
    dir_req_valid  = 1'b0;
    dir_req        = 2'd0;
    wall_rsp_valid = 1'b0;
    wall_blocked   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_x", sprite_x, 304);
    check("rst_y", sprite_y, 368);
    check("rst_dir", cur_dir, 2);
    check("rst_moving", moving, 0);
    check("rst_overrun", overrun, 0);
    check("rst_qv", wall_qry_valid, 0);
    check("rst_tx", wall_qry_tx, 0);
    check("rst_ty", wall_qry_ty, 0);

    //          rst  rv   rd  b0   b1   x    y    dir mov nq tx  ty
    vecs[0] = '{1'b1,1'b0,2'd0,1'b0,1'b0,304-1,368,2'd2,1'b1,1,6'd18,5'd23};
    vecs[1] = '{1'b0,1'b0,2'd0,1'b0,1'b0,302,  368,2'd2,1'b1,0,6'd0, 5'd0};
    vecs[2] = '{1'b0,1'b1,2'd3,1'b0,1'b0,303,  368,2'd3,1'b1,0,6'd0, 5'd0};
    vecs[3] = '{1'b0,1'b1,2'd2,1'b0,1'b0,302,  368,2'd2,1'b1,0,6'd0, 5'd0};
    vecs[4] = '{1'b1,1'b1,2'd0,1'b0,1'b0,304,  367,2'd0,1'b1,2,6'd19,5'd22};
    vecs[5] = '{1'b1,1'b1,2'd0,1'b1,1'b0,303,  368,2'd2,1'b1,2,6'd19,5'd22};
    vecs[6] = '{1'b0,1'b0,2'd0,1'b0,1'b0,302,  368,2'd2,1'b1,0,6'd0, 5'd0};
    vecs[7] = '{1'b1,1'b0,2'd0,1'b1,1'b0,304,  368,2'd2,1'b0,1,6'd18,5'd23};
    vecs[8] = '{1'b0,1'b0,2'd0,1'b0,1'b0,303,  368,2'd2,1'b1,1,6'd18,5'd23};

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].do_rst) do_reset();
      run_frame(vecs[v].req_v, vecs[v].req_d, vecs[v].blk0, vecs[v].blk1, nq, tx, ty);
      check($sformatf("v%0d_x", v), sprite_x, vecs[v].exp_x);
      check($sformatf("v%0d_y", v), sprite_y, vecs[v].exp_y);
      check($sformatf("v%0d_dir", v), cur_dir, vecs[v].exp_dir);
      check($sformatf("v%0d_moving", v), moving, vecs[v].exp_mov);
      check($sformatf("v%0d_nqry", v), nq, vecs[v].exp_nq);
      check($sformatf("v%0d_overrun", v), overrun, 0);
      if (vecs[v].exp_nq > 0) begin
        check($sformatf("v%0d_tx", v), tx, vecs[v].exp_tx);
        check($sformatf("v%0d_ty", v), ty, vecs[v].exp_ty);
      end
    end

    // Tick-to-position latency on an unaligned frame.
    do_reset();
    run_frame(1'b0, 2'd0, 1'b0, 1'b0, nq, tx, ty);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("lat_t1_x", sprite_x, 303);
    @(negedge clk);
    check("lat_t2_x", sprite_x, 303);
    @(negedge clk);
    check("lat_t3_x", sprite_x, 302);

    // Left tunnel wrap, then a reversal straight back through it.
    do_reset();
    for (int f = 0; f < 304; f++) run_frame(1'b0, 2'd0, 1'b0, 1'b0, nq, tx, ty);
    check("wrap_pre_x", sprite_x, 0);
    run_frame(1'b0, 2'd0, 1'b0, 1'b0, nq, tx, ty);
    check("wrap_nqry", nq, 1);
    check("wrap_tx", tx, 39);
    check("wrap_ty", ty, 23);
    check("wrap_x", sprite_x, 624);
    run_frame(1'b1, 2'd3, 1'b0, 1'b0, nq, tx, ty);
    check("wrapr_nqry", nq, 0);
    check("wrapr_dir", cur_dir, 3);
    check("wrapr_x", sprite_x, 0);

    // Downward travel saturates at the bottom edge.
    do_reset();
    run_frame(1'b1, 2'd1, 1'b0, 1'b0, nq, tx, ty);
    check("down_dir", cur_dir, 1);
    check("down_y", sprite_y, 369);
    for (int f = 0; f < 95; f++) run_frame(1'b0, 2'd0, 1'b0, 1'b0, nq, tx, ty);
    check("down_end_y", sprite_y, 464);
    check("down_end_moving", moving, 1);
    run_frame(1'b0, 2'd0, 1'b0, 1'b0, nq, tx, ty);
    check("clamp_ty", ty, 30);
    check("clamp_y", sprite_y, 464);
    check("clamp_moving", moving, 0);

    // Extra tick while the current-heading query is stalled.
    do_reset();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    k = 0;
    while (!wall_qry_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("ovr_qry_seen", wall_qry_valid, 1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("ovr_qry_held", wall_qry_valid, 1);
    check("ovr_tx_stable", wall_qry_tx, 18);
    check("ovr_x_wait", sprite_x, 304);
    wall_rsp_valid = 1'b1;
    wall_blocked   = 1'b0;
    @(negedge clk);
    wall_rsp_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("ovr_flag", overrun, 1);
    check("ovr_x", sprite_x, 303);
    run_frame(1'b0, 2'd0, 1'b0, 1'b0, nq, tx, ty);
    check("ovr_next_x", sprite_x, 302);
    check("ovr_sticky", overrun, 1);

    // Reset while the pending-direction query is outstanding.
    do_reset();
    @(negedge clk);
    dir_req_valid = 1'b1;
    dir_req       = 2'd0;
    @(negedge clk);
    dir_req_valid = 1'b0;
    frame_tick    = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check("mid_qv", wall_qry_valid, 1);
    check("mid_ty", wall_qry_ty, 22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_qv", wall_qry_valid, 0);
    check("mid_rst_x", sprite_x, 304);
    check("mid_rst_y", sprite_y, 368);
    check("mid_rst_tx", wall_qry_tx, 0);
    wall_rsp_valid = 1'b1;
    wall_blocked   = 1'b0;
    @(negedge clk);
    wall_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_dir", cur_dir, 2);
    check("late_rsp_y", sprite_y, 368);
    check("late_rsp_qv", wall_qry_valid, 0);
    run_frame(1'b0, 2'd0, 1'b0, 1'b0, nq, tx, ty);
    check("after_rst_nqry", nq, 1);
    check("after_rst_tx", tx, 18);
    check("after_rst_ty", ty, 23);
    check("after_rst_x", sprite_x, 303);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Per-frame position generator for one maze sprite (Pacman or a ghost).
- Produces the sprite_x/sprite_y coordinates consumed by the sprite engine's hit-test and relative-coordinate logic.
- Latches joystick/AI direction requests and checks walls through a request/response query port to the maze block.
- Once per frame_tick it advances the sprite by STEP pixels, with horizontal tunnel wrap.

Parameters:
- TILE, 16: tile pitch in pixels. Power of two. STEP must divide it.
- STEP, 1: pixels moved per frame.
- X_MAX, 624: largest legal sprite_x. Must be a multiple of TILE. X_MIN is 0.
- Y_MAX, 464: largest legal sprite_y. Must be a multiple of TILE. Y_MIN is 0.
- START_X, 304: sprite_x after reset. Must be a multiple of TILE.
- START_Y, 368: sprite_y after reset. Must be a multiple of TILE.

Ports:
- VGA_CLK, in, 1: pixel clock; all state changes on its rising edge.
- HRESET, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per frame (vblank).
- dir_req_valid, in, 1: direction request strobe.
- dir_req, in, 2: requested direction. 0 up, 1 down, 2 left, 3 right.
- wall_qry_valid, out, 1: wall query outstanding.
- wall_qry_tx, out, 6: tile column of the queried neighbour.
- wall_qry_ty, out, 5: tile row of the queried neighbour.
- wall_rsp_valid, in, 1: wall response strobe.
- wall_blocked, in, 1: queried tile is a wall; valid with wall_rsp_valid.
- sprite_x, out, 10: sprite left edge, in pixels.
- sprite_y, out, 10: sprite top edge, in pixels.
- cur_dir, out, 2: current heading.
- moving, out, 1: 1 if the last frame advanced the sprite.
- overrun, out, 1: sticky flag, set when a frame_tick arrives while busy.

Behaviour:
- Reset (HRESET high at a clock edge) forces the following:
  - sprite_x=START_X, sprite_y=START_Y, cur_dir=2 (left);
  - moving=0, overrun=0, wall_qry_valid=0, wall_qry_tx/ty=0;
  - pending request cleared, state IDLE.
  - Reset mid-query abandons the query. A wall_rsp_valid arriving afterwards is ignored.
- Pending register:
  - dir_req_valid in any cycle loads dir_req as pending. A later request overwrites an earlier one.
  - If a load and a FSM clear of pending happen in the same cycle, the load wins.
- Reversal: a pending direction equal to the opposite of cur_dir is adopted at the next frame_tick without a query, even mid-tile. It is then cleared.
- Aligned means sprite_x%TILE==0 and sprite_y%TILE==0.
- Neighbour tile in direction d is (sprite_x/TILE, sprite_y/TILE) offset by one tile.
  - Column wraps modulo X_MAX/TILE+1.
  - Row is not wrapped.
- States:
  - IDLE: frame_tick -> CHK.
  - CHK (1 cycle):
    - pending reversal: adopt it, go to MOVE;
    - unaligned: go to MOVE with cur_dir;
    - aligned with a pending non-reversal request: go to QRY_PEND;
    - aligned with no pending request: go to QRY_CUR.
  - QRY_PEND: wall_qry_valid=1 with the neighbour for the pending direction. Hold until wall_rsp_valid.
    - Not blocked: cur_dir<=pending, clear pending.
    - Blocked: keep pending.
    - Either way go to QRY_CUR.
  - QRY_CUR: query the neighbour for cur_dir. wall_qry_valid stays 1 across the transition.
    - Blocked: moving<=0, go to IDLE.
    - Otherwise go to MOVE.
  - MOVE (1 cycle): update position, moving<=1, go to IDLE.
- Handshake: a query completes in any cycle with wall_qry_valid && wall_rsp_valid. Query fields are stable until completion. Wait is unbounded.
- Timing: for an unaligned frame, frame_tick at cycle t makes the new position visible at t+3.
- Arithmetic:
  - up: y-=STEP; down: y+=STEP; left: x-=STEP; right: x+=STEP.
  - Moving left from x=0 gives x=X_MAX. Moving right from x=X_MAX gives x=0.
  - Vertical motion saturates at 0/Y_MAX and sets moving<=0 when clamped.
- frame_tick in any state other than IDLE is ignored and sets overrun=1 (cleared only by reset).

Test Plan:
- Reset, then 3 frame_ticks; first two ticks answered with wall_blocked=0, third tick's query not answered -> sprite_x=304 at reset, then 303 after the first tick (cur_dir=left, moving=1), 302 after the second.
- At x=304,y=368, dir_req=0 (up), response 0 -> cur_dir=0, sprite_y=367, pending cleared.
  - With wall_blocked=1 on the up query instead: cur_dir stays 2, x=303, pending still 0.
- Heading right at x=303, dir_req=2 (left) -> x=302 next frame, no wall_qry_valid seen.
- x=0, cur_dir=left, wall response 0 -> sprite_x=624.
  - With x=0, wall_qry_tx=39 during the query.
- frame_tick pulsed while in QRY_CUR with the response withheld 5 cycles -> overrun=1, exactly one position update.
- HRESET asserted during QRY_PEND -> next cycle wall_qry_valid=0, position=START.
  - A late wall_rsp_valid changes nothing.
